branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Consumer of the jump/branch decode flags: owns the program counter of the single-cycle core.
- Evaluates branch conditions on register operands and selects the next PC: sequential, jump, jump-register or branch target.
- Generates link write-back for jump-and-link.
- Maintains halt state and branch statistics counters for the board display.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- COUNT_W, 16, width of each statistics counter.

Ports:
- in_clk, input, 1, system clock, rising edge.
- in_rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, current instruction valid; flags ignored when low.
- in_stall, input, 1, hold PC and counters this cycle.
- in_halt, input, 1, syscall halt request.
- in_resume, input, 1, leave HALTED.
- in_J, input, 1, jump class (J, JAL, JR).
- in_JW, input, 1, jump-and-link.
- in_JR, input, 1, jump register.
- in_BEQ, input, 1, branch if equal.
- in_BNE, input, 1, branch if not equal.
- in_BGEZ, input, 1, branch if rs >= 0 signed.
- in_index, input, 26, J-format target index.
- in_imm, input, 16, branch offset in words.
- in_rs_data, input, 32, rs operand.
- in_rt_data, input, 32, rt operand.
- out_pc, output, 32, current PC (registered).
- out_link_we, output, 1, write out_link_addr to $31 (combinational).
- out_link_addr, output, 32, PC+4.
- out_taken, output, 1, control transfer this cycle (combinational).
- out_halted, output, 1, FSM in HALTED.
- out_misalign, output, 1, sticky: redirect target with bits[1:0] != 0.
- out_cycle_cnt, output, COUNT_W, RUN cycles executed.
- out_jump_cnt, output, COUNT_W, unconditional jumps.
- out_branch_cnt, output, COUNT_W, conditional branches executed.
- out_taken_cnt, output, COUNT_W, conditional branches taken.

Behaviour:
- Reset (async, in_rst_n=0):
  - out_pc=RESET_PC; FSM=RUN.
  - out_misalign=0; all counters=0.
  - out_halted=0, out_taken=0, out_link_we=0.
- pc4 = out_pc+4, mod 2^32; out_link_addr=pc4.
- Target select, priority order:
  - in_JR: in_rs_data.
  - else in_J: {pc4[31:28], in_index, 2'b00}.
  - else conditional branch: pc4 + (sign-extended in_imm << 2), mod 2^32.
- Conditions:
  - BEQ: rs==rt.
  - BNE: rs!=rt.
  - BGEZ: rs[31]==0.
  - Priority BEQ > BNE > BGEZ when several are asserted.
- act = in_valid & ~in_stall & FSM==RUN.
- out_taken = act & (in_J | cond true).
- out_link_we = act & in_JW.
- FSM RUN, each rising edge with act:
  - out_pc <= taken ? target : pc4.
  - out_cycle_cnt +1.
  - out_jump_cnt +1 if in_J.
  - out_branch_cnt +1 if any of BEQ/BNE/BGEZ and not in_J.
  - out_taken_cnt +1 if that branch is taken.
- Counters wrap at 2^COUNT_W.
- in_stall=1 or in_valid=0: PC and counters hold.
- Halt:
  - RUN and in_halt & in_valid & ~in_stall: go to HALTED next edge; PC <= pc4; cycle_cnt +1. Branch flags are ignored that cycle.
  - HALTED: PC and counters frozen, out_taken=0, out_halted=1.
  - in_resume=1: return to RUN next edge.
  - in_halt and in_resume both high in RUN: halt wins.
- Misalign: set on a taken redirect whose target[1:0]!=0. The PC still loads the target. Cleared only by reset.
- Reset mid-operation: immediate return to reset values, no partial update.

Test Plan:
- Reset release, in_valid=1, no flags, 3 cycles -> out_pc 0x0,0x4,0x8,0xC; cycle_cnt=3; taken_cnt=0.
- PC=0x100, BEQ, rs=rt=5, imm=16'hFFFC -> out_taken=1; next PC=0x0F4; branch_cnt=1, taken_cnt=1. Then BNE with rs=rt -> next PC=PC+4; taken_cnt unchanged.
- PC=0x0040_0010, J+JW, index=26'h0000100 -> out_link_we=1, out_link_addr=0x0040_0014; next PC=0x0000_0400; jump_cnt=1.
- J+JR, rs=0x0000_0202 -> next PC=0x202; out_misalign=1 and stays 1 after further sequential cycles.
- BGEZ, rs=0x8000_0000 -> not taken. Then rs=0 -> taken. Assert in_stall in the middle -> PC and counters unchanged.
- in_halt at PC=0x20 -> out_halted=1, PC=0x24 frozen for 5 cycles. Then in_resume -> RUN; next valid cycle PC=0x28. Assert in_rst_n=0 mid-halt -> PC=RESET_PC, out_halted=0.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// Instruction-side bus of the branch resolve unit: decode flags and operands in,
// program counter, control-transfer status and statistics counters out.
interface branch_resolve_unit_if #(
   parameter int COUNT_W = 16
);
   logic                in_valid;
   logic                in_stall;
   logic                in_halt;
   logic                in_resume;
   logic                in_J;
   logic                in_JW;
   logic                in_JR;
   logic                in_BEQ;
   logic                in_BNE;
   logic                in_BGEZ;
   logic [25:0]         in_index;
   logic [15:0]         in_imm;
   logic [31:0]         in_rs_data;
   logic [31:0]         in_rt_data;
   logic [31:0]         out_pc;
   logic                out_link_we;
   logic [31:0]         out_link_addr;
   logic                out_taken;
   logic                out_halted;
   logic                out_misalign;
   logic [COUNT_W-1:0]  out_cycle_cnt;
   logic [COUNT_W-1:0]  out_jump_cnt;
   logic [COUNT_W-1:0]  out_branch_cnt;
   logic [COUNT_W-1:0]  out_taken_cnt;

   modport slave (
      input  in_valid, in_stall, in_halt, in_resume,
      input  in_J, in_JW, in_JR, in_BEQ, in_BNE, in_BGEZ,
      input  in_index, in_imm, in_rs_data, in_rt_data,
      output out_pc, out_link_we, out_link_addr, out_taken, out_halted, out_misalign,
      output out_cycle_cnt, out_jump_cnt, out_branch_cnt, out_taken_cnt
   );

   modport master (
      output in_valid, in_stall, in_halt, in_resume,
      output in_J, in_JW, in_JR, in_BEQ, in_BNE, in_BGEZ,
      output in_index, in_imm, in_rs_data, in_rt_data,
      input  out_pc, out_link_we, out_link_addr, out_taken, out_halted, out_misalign,
      input  out_cycle_cnt, out_jump_cnt, out_branch_cnt, out_taken_cnt
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// Program counter owner of the single-cycle core: resolves jumps and branches,
// drives the link write-back, tracks halt state and keeps branch statistics.
module branch_resolve_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          COUNT_W  = 16
) (
   input  logic                  in_clk,
   input  logic                  in_rst_n,
   branch_resolve_unit_if.slave  bus
);

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [31:0]          r_pc;
   logic                 r_misalign;
   logic [COUNT_W-1:0]   r_cycle_cnt;
   logic [COUNT_W-1:0]   r_jump_cnt;
   logic [COUNT_W-1:0]   r_branch_cnt;
   logic [COUNT_W-1:0]   r_taken_cnt;

   logic [31:0]          w_pc4;
   logic [31:0]          w_br_off;
   logic [31:0]          w_target;
   logic                 w_act;
   logic                 w_halt_req;
   logic                 w_exec;
   logic                 w_is_branch;
   logic                 w_cond;
   logic                 w_taken;

   assign w_pc4       = r_pc + 32'd4;
   assign w_br_off    = {{14{bus.in_imm[15]}}, bus.in_imm, 2'b00};
   // Reset is folded in so the combinational strobes read zero while it is held.
   assign w_act       = in_rst_n & bus.in_valid & ~bus.in_stall & (r_state == ST_RUN);
   assign w_halt_req  = w_act & bus.in_halt;
   assign w_exec      = w_act & ~bus.in_halt;
   assign w_is_branch = bus.in_BEQ | bus.in_BNE | bus.in_BGEZ;
   assign w_taken     = w_exec & (bus.in_J | w_cond);

   // Branch condition, BEQ over BNE over BGEZ.
   always_comb begin
      w_cond = 1'b0;
      if (bus.in_BEQ) begin
         w_cond = (bus.in_rs_data == bus.in_rt_data);
      end else if (bus.in_BNE) begin
         w_cond = (bus.in_rs_data != bus.in_rt_data);
      end else if (bus.in_BGEZ) begin
         w_cond = ~bus.in_rs_data[31];
      end else begin
         w_cond = 1'b0;
      end
   end

   // Redirect target, JR over J over branch offset.
   always_comb begin
      w_target = w_pc4;
      if (bus.in_JR) begin
         w_target = bus.in_rs_data;
      end else if (bus.in_J) begin
         w_target = {w_pc4[31:28], bus.in_index, 2'b00};
      end else begin
         w_target = w_pc4 + w_br_off;
      end
   end

   // Run/halt state register.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: a halt request outranks a same-cycle resume.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN: begin
            if (w_halt_req) begin
               w_state_nxt = ST_HALTED;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_HALTED: begin
            if (bus.in_resume) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_HALTED;
            end
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   // PC, sticky misalign flag and statistics counters.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_pc         <= RESET_PC;
         r_misalign   <= 1'b0;
         r_cycle_cnt  <= '0;
         r_jump_cnt   <= '0;
         r_branch_cnt <= '0;
         r_taken_cnt  <= '0;
      end else if (w_act) begin
         r_cycle_cnt <= r_cycle_cnt + COUNT_W'(1'b1);
         r_pc        <= w_taken ? w_target : w_pc4;
         if (w_exec && bus.in_J) begin
            r_jump_cnt <= r_jump_cnt + COUNT_W'(1'b1);
         end
         if (w_exec && w_is_branch && !bus.in_J) begin
            r_branch_cnt <= r_branch_cnt + COUNT_W'(1'b1);
            if (w_cond) begin
               r_taken_cnt <= r_taken_cnt + COUNT_W'(1'b1);
            end
         end
         if (w_taken && (w_target[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
         end
      end
   end

   assign bus.out_pc         = r_pc;
   assign bus.out_link_addr  = w_pc4;
   assign bus.out_link_we    = w_exec & bus.in_JW;
   assign bus.out_taken      = w_taken;
   assign bus.out_halted     = (r_state == ST_HALTED);
   assign bus.out_misalign   = r_misalign;
   assign bus.out_cycle_cnt  = r_cycle_cnt;
   assign bus.out_jump_cnt   = r_jump_cnt;
   assign bus.out_branch_cnt = r_branch_cnt;
   assign bus.out_taken_cnt  = r_taken_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a reference model of the PC/counter
// rules checked every cycle, plus hand-computed literal expectations.
module tb_branch_resolve_unit;

   logic in_clk;
   logic in_rst_n;
   int   checks;
   int   failures;

   branch_resolve_unit_if #(.COUNT_W(16)) bus ();

   branch_resolve_unit #(.RESET_PC(32'h0000_0000), .COUNT_W(16)) dut (
      .in_clk   (in_clk),
      .in_rst_n (in_rst_n),
      .bus      (bus)
   );

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   // Reference model state
   logic [31:0] m_pc;
   logic        m_halted;
   logic        m_mis;
   logic [15:0] m_cyc, m_jmp, m_br, m_tk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic m_active();
      return in_rst_n && bus.in_valid && !bus.in_stall && !m_halted;
   endfunction

   function automatic logic m_cond();
      if (bus.in_BEQ)  return bus.in_rs_data == bus.in_rt_data;
      if (bus.in_BNE)  return bus.in_rs_data != bus.in_rt_data;
      if (bus.in_BGEZ) return $signed(bus.in_rs_data) >= 0;
      return 1'b0;
   endfunction

   function automatic logic m_taken();
      return m_active() && !bus.in_halt && (bus.in_J || m_cond());
   endfunction

   function automatic logic [31:0] m_target();
      logic [31:0] pc4;
      int          off;
      pc4 = m_pc + 32'd4;
      if (bus.in_JR) return bus.in_rs_data;
      if (bus.in_J)  return (pc4 & 32'hF000_0000) | (32'(bus.in_index) * 32'd4);
      off = int'($signed(bus.in_imm)) * 4;
      return pc4 + 32'(off);
   endfunction

   // Model update on the same edge the DUT updates.
   always @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         m_pc <= 32'h0; m_halted <= 1'b0; m_mis <= 1'b0;
         m_cyc <= 16'd0; m_jmp <= 16'd0; m_br <= 16'd0; m_tk <= 16'd0;
      end else if (m_halted) begin
         if (bus.in_resume) m_halted <= 1'b0;
      end else if (m_active()) begin
         m_cyc <= m_cyc + 16'd1;
         if (bus.in_halt) begin
            m_pc     <= m_pc + 32'd4;
            m_halted <= 1'b1;
         end else begin
            m_pc <= m_taken() ? m_target() : m_pc + 32'd4;
            if (bus.in_J) m_jmp <= m_jmp + 16'd1;
            if (!bus.in_J && (bus.in_BEQ || bus.in_BNE || bus.in_BGEZ)) begin
               m_br <= m_br + 16'd1;
               if (m_cond()) m_tk <= m_tk + 16'd1;
            end
            if (m_taken() && (m_target() % 4 != 0)) m_mis <= 1'b1;
         end
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge in_clk) begin
      chk("pc",        bus.out_pc,                m_pc);
      chk("link_addr", bus.out_link_addr,         m_pc + 32'd4);
      chk("link_we",   32'(bus.out_link_we),      32'(m_active() && !bus.in_halt && bus.in_JW));
      chk("taken",     32'(bus.out_taken),        32'(m_taken()));
      chk("halted",    32'(bus.out_halted),       32'(m_halted));
      chk("misalign",  32'(bus.out_misalign),     32'(m_mis));
      chk("cycle_cnt", 32'(bus.out_cycle_cnt),    32'(m_cyc));
      chk("jump_cnt",  32'(bus.out_jump_cnt),     32'(m_jmp));
      chk("br_cnt",    32'(bus.out_branch_cnt),   32'(m_br));
      chk("tk_cnt",    32'(bus.out_taken_cnt),    32'(m_tk));
   end

   task automatic step();
      @(posedge in_clk);
      #2;
   endtask

   task automatic clr();
      bus.in_halt = 1'b0; bus.in_resume = 1'b0;
      bus.in_J = 1'b0; bus.in_JW = 1'b0; bus.in_JR = 1'b0;
      bus.in_BEQ = 1'b0; bus.in_BNE = 1'b0; bus.in_BGEZ = 1'b0;
      bus.in_index = 26'h0; bus.in_imm = 16'h0;
      bus.in_rs_data = 32'h0; bus.in_rt_data = 32'h0;
      bus.in_stall = 1'b0;
   endtask

   task automatic jr_to(input logic [31:0] addr);
      clr();
      bus.in_J = 1'b1; bus.in_JR = 1'b1; bus.in_rs_data = addr;
      step();
      clr();
   endtask

   initial begin
      checks = 0; failures = 0;
      in_rst_n = 1'b0;
      bus.in_valid = 1'b0;
      clr();
      repeat (3) @(posedge in_clk);
      #2;
      chk("lit_rst_pc", bus.out_pc, 32'h0);
      chk("lit_rst_halted", 32'(bus.out_halted), 32'h0);
      in_rst_n = 1'b1;

      // Sequential fetch
      bus.in_valid = 1'b1;
      step(); chk("lit_seq_pc1", bus.out_pc, 32'h4);
      step(); chk("lit_seq_pc2", bus.out_pc, 32'h8);
      step(); chk("lit_seq_pc3", bus.out_pc, 32'hC);
      chk("lit_seq_cyc", 32'(bus.out_cycle_cnt), 32'd3);
      chk("lit_seq_tk", 32'(bus.out_taken_cnt), 32'd0);

      // BEQ taken backwards, then BNE not taken
      jr_to(32'h0000_0100);
      bus.in_BEQ = 1'b1; bus.in_rs_data = 32'd5; bus.in_rt_data = 32'd5; bus.in_imm = 16'hFFFC;
      #1 chk("lit_beq_taken", 32'(bus.out_taken), 32'h1);
      step(); chk("lit_beq_pc", bus.out_pc, 32'h0000_00F4);
      chk("lit_beq_br", 32'(bus.out_branch_cnt), 32'd1);
      chk("lit_beq_tk", 32'(bus.out_taken_cnt), 32'd1);
      clr();
      bus.in_BNE = 1'b1; bus.in_rs_data = 32'd5; bus.in_rt_data = 32'd5; bus.in_imm = 16'h0010;
      step(); chk("lit_bne_pc", bus.out_pc, 32'h0000_00F8);
      chk("lit_bne_tk", 32'(bus.out_taken_cnt), 32'd1);

      // Jump-and-link
      jr_to(32'h0040_0010);
      bus.in_J = 1'b1; bus.in_JW = 1'b1; bus.in_index = 26'h0000100;
      #1 chk("lit_jal_we", 32'(bus.out_link_we), 32'h1);
      chk("lit_jal_link", bus.out_link_addr, 32'h0040_0014);
      step(); chk("lit_jal_pc", bus.out_pc, 32'h0000_0400);
      clr();

      // Misaligned JR target, sticky
      jr_to(32'h0000_0202);
      chk("lit_mis_pc", bus.out_pc, 32'h0000_0202);
      step(); step();
      chk("lit_mis_sticky", 32'(bus.out_misalign), 32'h1);
      chk("lit_mis_seq_pc", bus.out_pc, 32'h0000_020A);

      // BGEZ negative, then stalled, then taken
      bus.in_BGEZ = 1'b1; bus.in_rs_data = 32'h8000_0000; bus.in_imm = 16'h0004;
      step(); chk("lit_bgez_nt_pc", bus.out_pc, 32'h0000_020E);
      bus.in_rs_data = 32'h0; bus.in_stall = 1'b1;
      #1 chk("lit_stall_taken", 32'(bus.out_taken), 32'h0);
      step(); step(); chk("lit_stall_pc", bus.out_pc, 32'h0000_020E);
      bus.in_stall = 1'b0;
      step(); chk("lit_bgez_t_pc", bus.out_pc, 32'h0000_0222);
      clr();
      bus.in_valid = 1'b0;
      step(); chk("lit_invalid_pc", bus.out_pc, 32'h0000_0222);
      bus.in_valid = 1'b1;

      // Halt (with simultaneous resume, halt wins), frozen, resume
      jr_to(32'h0000_0020);
      bus.in_halt = 1'b1; bus.in_resume = 1'b1;
      step(); clr();
      chk("lit_halt_flag", 32'(bus.out_halted), 32'h1);
      bus.in_J = 1'b1; bus.in_JR = 1'b1; bus.in_rs_data = 32'h0000_0500;
      repeat (5) step();
      chk("lit_halt_pc", bus.out_pc, 32'h0000_0024);
      clr();
      bus.in_resume = 1'b1;
      step(); clr();
      chk("lit_resume_flag", 32'(bus.out_halted), 32'h0);
      step(); chk("lit_resume_pc", bus.out_pc, 32'h0000_0028);

      // Reset while halted
      bus.in_halt = 1'b1;
      step(); clr();
      bus.in_valid = 1'b0;
      step();
      in_rst_n = 1'b0;
      #1 chk("lit_midrst_pc", bus.out_pc, 32'h0);
      chk("lit_midrst_halted", 32'(bus.out_halted), 32'h0);
      step();
      in_rst_n = 1'b1;
      bus.in_valid = 1'b1;
      step(); step();
      chk("lit_post_pc", bus.out_pc, 32'h8);

      @(negedge in_clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
